// File: rtl/banco_reg_multiporta.sv
// banco_reg_multiporta: multi-port register file with two registered read ports,
// one write port, and a hardware scrub sequence that clears every register.
// Optional macro BANCO_REG_FWD_EN enables write-to-read forwarding.
module banco_reg_multiporta #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    output logic              busy,
    input  logic              EscReg,
    input  logic [ADDR_W-1:0] RegW,
    input  logic [DATA_W-1:0] Dado_Escrito,
    input  logic [ADDR_W-1:0] ReadA,
    input  logic [ADDR_W-1:0] ReadB,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        SCRUB
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] scrubPtr;
    logic [ADDR_W-1:0] nextPtr;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrAccept;
    logic [DATA_W-1:0] rdA;
    logic [DATA_W-1:0] rdB;

    // Next-state logic for the scrub FSM and write acceptance decode.
    always_comb begin
        busy      = (state == SCRUB);
        wrAccept  = !busy && EscReg && !((R0_ZERO != 0) && (RegW == '0));
        nextState = state;
        nextPtr   = scrubPtr;
        case (state)
            IDLE: begin
                if (clear) begin
                    nextState = SCRUB;
                    nextPtr   = '0;
                end
            end
            SCRUB: begin
                // Pointer all-ones is the last entry; leave before it can wrap.
                nextPtr = scrubPtr + 1'b1;
                if (&scrubPtr) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State and scrub pointer registers; reset starts a fresh scrub.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= SCRUB;
            scrubPtr <= '0;
        end else begin
            state    <= nextState;
            scrubPtr <= nextPtr;
        end
    end

    // Storage update: scrub zeroing has precedence, user writes only when idle.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (busy) begin
                regs[scrubPtr] <= '0;
            end else if (wrAccept) begin
                regs[RegW] <= Dado_Escrito;
            end
        end
    end

    // Read data selection for both ports, including optional forwarding.
    always_comb begin
        rdA = regs[ReadA];
        rdB = regs[ReadB];
`ifdef BANCO_REG_FWD_EN
        if (wrAccept && (ReadA == RegW)) begin
            rdA = Dado_Escrito;
        end
        if (wrAccept && (ReadB == RegW)) begin
            rdB = Dado_Escrito;
        end
`else
`endif
        if ((R0_ZERO != 0) && (ReadA == '0)) begin
            rdA = '0;
        end
        if ((R0_ZERO != 0) && (ReadB == '0)) begin
            rdB = '0;
        end
    end

    // Registered read outputs; forced to zero while scrubbing or in reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            OutA <= '0;
            OutB <= '0;
        end else if (busy) begin
            OutA <= '0;
            OutB <= '0;
        end else begin
            OutA <= rdA;
            OutB <= rdB;
        end
    end

endmodule

// File: tb/tb_banco_reg_multiporta.sv
// Directed testbench for banco_reg_multiporta (default parameters, 32 x 32).
module tb_banco_reg_multiporta;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic        busy;
    logic        EscReg;
    logic [4:0]  RegW;
    logic [31:0] Dado_Escrito;
    logic [4:0]  ReadA;
    logic [4:0]  ReadB;
    logic [31:0] OutA;
    logic [31:0] OutB;

    int unsigned vectors;
    int unsigned misses;
    int unsigned cnt;

    banco_reg_multiporta #(
        .DATA_W (32),
        .ADDR_W (5),
        .R0_ZERO(1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .busy        (busy),
        .EscReg      (EscReg),
        .RegW        (RegW),
        .Dado_Escrito(Dado_Escrito),
        .ReadA       (ReadA),
        .ReadB       (ReadB),
        .OutA        (OutA),
        .OutB        (OutB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            misses++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        EscReg       = 1'b1;
        RegW         = a;
        Dado_Escrito = d;
        tick();
        EscReg       = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 32; i++) begin
            ReadA = 5'(i);
            ReadB = 5'(31 - i);
            tick();
            chk({tag, "_A"}, OutA, 32'h0);
            chk({tag, "_B"}, OutB, 32'h0);
        end
    endtask

    task automatic countBusy(output int unsigned n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vectors      = 0;
        misses       = 0;
        reset_n      = 1'b0;
        clear        = 1'b0;
        EscReg       = 1'b0;
        RegW         = '0;
        Dado_Escrito = '0;
        ReadA        = '0;
        ReadB        = '0;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_outA", OutA, 32'h0);
        chk("rst_outB", OutB, 32'h0);
        reset_n = 1'b1;
        countBusy(cnt);
        chk("rst_scrub_len", cnt, 32'd32);
        checkAllZero("rst_rd");

        // Write r7, read on both ports one cycle later.
        wr(5'd7, 32'hDEADBEEF);
        ReadA = 5'd7;
        ReadB = 5'd7;
        tick();
        chk("r7_A", OutA, 32'hDEADBEEF);
        chk("r7_B", OutB, 32'hDEADBEEF);

        // Writes to r0 are discarded.
        wr(5'd0, 32'h12345678);
        ReadA = 5'd0;
        ReadB = 5'd0;
        tick();
        chk("r0_A", OutA, 32'h0);
        chk("r0_B", OutB, 32'h0);

        // Same-cycle write and read of r3.
        wr(5'd3, 32'h00000001);
        EscReg       = 1'b1;
        RegW         = 5'd3;
        Dado_Escrito = 32'hA5A5A5A5;
        ReadA        = 5'd3;
        ReadB        = 5'd7;
        tick();
        EscReg = 1'b0;
`ifdef BANCO_REG_FWD_EN
        chk("fwd_r3", OutA, 32'hA5A5A5A5);
`else
        chk("fwd_r3", OutA, 32'h00000001);
`endif
        chk("fwd_other", OutB, 32'hDEADBEEF);
        tick();
        chk("r3_after", OutA, 32'hA5A5A5A5);

        // Fill r1..r31 with their index.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i));
        end
        ReadA = 5'd5;
        ReadB = 5'd31;
        tick();
        chk("fill_r5", OutA, 32'd5);
        chk("fill_r31", OutB, 32'd31);

        // Scrub: late write to r5 and a second clear must both be ignored.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("scrub_busy", {31'b0, busy}, 32'h1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            EscReg       = (cnt == 20);
            RegW         = 5'd5;
            Dado_Escrito = 32'hFF;
            clear        = (cnt == 10);
            ReadA        = 5'(cnt + 1);
            ReadB        = 5'd5;
            tick();
            cnt++;
            chk("scrub_rdA", OutA, 32'h0);
            chk("scrub_rdB", OutB, 32'h0);
        end
        EscReg = 1'b0;
        clear  = 1'b0;
        chk("scrub_len", cnt, 32'd32);
        checkAllZero("scrub_rd");

        // Reset in the middle of a scrub restarts it from entry 0.
        wr(5'd9, 32'h99);
        wr(5'd20, 32'h20);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("mid_reach20", cnt, 32'd20);
        reset_n = 1'b0;
        clear   = 1'b1;
        tick();
        clear   = 1'b0;
        reset_n = 1'b1;
        chk("mid_rst_busy", {31'b0, busy}, 32'h1);
        chk("mid_rst_outA", OutA, 32'h0);
        countBusy(cnt);
        chk("mid_scrub_len", cnt, 32'd32);
        checkAllZero("mid_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
